// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with tick-based debounce and a
//            saturating decimal accumulator (0..9999).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int NUM_WIDTH      = 14
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [3:0]           row_in,
  output logic [3:0]           col_out,
  output logic [3:0]           key_code,
  output logic                 key_valid,
  output logic [NUM_WIDTH-1:0] number
);

  localparam int              CW        = $clog2(SCAN_DIV);
  localparam int              AW        = (NUM_WIDTH + 5 > 17) ? NUM_WIDTH + 5 : 17;
  localparam logic [CW-1:0]   TICK_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_LAST  = 4'(DEBOUNCE_TICKS);
  localparam logic [AW-1:0]   NUM_MAX   = AW'(9999);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           row_meta_q, row_sync_q;
  logic [CW-1:0]        tick_cnt_q;
  logic [1:0]           col_q, col_d;
  logic [1:0]           row_q, row_d;
  logic [3:0]           stable_q, stable_d;
  logic [3:0]           key_code_q, key_code_d;
  logic                 key_valid_q, key_valid_d;
  logic [NUM_WIDTH-1:0] number_q, number_d;
  logic                 tick;
  logic                 rows_idle;
  logic [1:0]           low_row;
  logic [3:0]           stable_inc;
  logic [AW-1:0]        acc;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign rows_idle  = &row_sync_q;
  assign stable_inc = stable_q + 4'd1;

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    low_row = 2'd3;
    if (!row_sync_q[0])      low_row = 2'd0;
    else if (!row_sync_q[1]) low_row = 2'd1;
    else if (!row_sync_q[2]) low_row = 2'd2;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    stable_d    = stable_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (rows_idle) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d    = low_row;
            stable_d = 4'd1;
            state_d  = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_sync_q[row_q]) begin
            stable_d = stable_inc;
            if (stable_inc == DEB_LAST) begin
              key_code_d  = key_map(row_q, col_q);
              key_valid_d = 1'b1;
              state_d     = ST_HELD;
            end
          end else begin
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (rows_idle) begin
            stable_d = 4'd1;
            state_d  = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (rows_idle) begin
            stable_d = stable_inc;
            if (stable_inc == DEB_LAST) begin
              col_d   = col_q + 2'd1;
              state_d = ST_SCAN;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // Widened so number*10+digit cannot overflow before the saturation compare.
  assign acc = AW'(number_q) * AW'(10) + AW'(key_code_q);

  always_comb begin
    number_d = number_q;
    if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        if (acc <= NUM_MAX) number_d = acc[NUM_WIDTH-1:0];
      end else if (key_code_q == 4'hA) begin
        number_d = '0;
      end else if (key_code_q == 4'hB) begin
        number_d = number_q / NUM_WIDTH'(10);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      row_meta_q  <= '0;
      row_sync_q  <= '0;
      tick_cnt_q  <= '0;
      state_q     <= ST_SCAN;
      col_q       <= '0;
      row_q       <= '0;
      stable_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      number_q    <= '0;
    end else begin
      row_meta_q  <= row_in;
      row_sync_q  <= row_meta_q;
      tick_cnt_q  <= tick ? '0 : tick_cnt_q + CW'(1);
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      stable_q    <= stable_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      number_q    <= number_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign number    = number_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// Testbench for keypad_scanner: simulated keypad matrix plus a tick-level
// behavioural model of scanning, debounce and the decimal accumulator.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int NW       = 14;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [3:0]    row_in;
  logic [3:0]    col_out;
  logic [3:0]    key_code;
  logic          key_valid;
  logic [NW-1:0] number;
  logic [15:0]   pressed = '0;

  int checks   = 0;
  int failures = 0;

  int            kv_count    = 0;
  logic          num_pending = 1'b0;
  logic [NW-1:0] num_after   = '0;

  int tb_cnt    = 0;
  int m_col     = 0;
  int m_cand    = -1;
  int m_run     = 0;
  int m_up      = 0;
  int m_code    = 0;
  int m_num     = 0;
  int m_accepts = 0;
  bit m_held    = 1'b0;

  int KEYMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_TICKS(DEB),
    .NUM_WIDTH     (NW)
  ) dut (
    .Clk      (clk),
    .Rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .number   (number)
  );

  // Physical keypad: a pressed key shorts its row to any column driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic int first_row(input logic [15:0] keys, input int col);
    for (int r = 0; r < 4; r++)
      if (keys[r*4+col]) return r;
    return -1;
  endfunction

  function automatic int next_num(input int num, input int code);
    if (code <= 9)   return (num * 10 + code <= 9999) ? num * 10 + code : num;
    if (code == 10)  return 0;
    if (code == 11)  return num / 10;
    return num;
  endfunction

  function automatic logic [3:0] col_hot(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return 4'b1111 ^ (one << idx);
  endfunction

  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == SCAN_DIV - 1) ? 0 : tb_cnt + 1;
  end

  // Reference model: one decision per scan tick, driven by the pressed-key set.
  always @(posedge clk) begin
    if (rst) begin
      m_col  <= 0;
      m_cand <= -1;
      m_run  <= 0;
      m_up   <= 0;
      m_held <= 1'b0;
      m_code <= 0;
      m_num  <= 0;
    end else if (tb_cnt == SCAN_DIV - 1) begin
      if (!m_held && m_cand < 0) begin
        if (first_row(pressed, m_col) < 0) m_col <= (m_col + 1) % 4;
        else begin
          m_cand <= first_row(pressed, m_col);
          m_run  <= 1;
        end
      end else if (!m_held) begin
        if (pressed[m_cand*4+m_col]) begin
          if (m_run + 1 >= DEB) begin
            m_held    <= 1'b1;
            m_cand    <= -1;
            m_up      <= 0;
            m_accepts <= m_accepts + 1;
            m_code    <= KEYMAP[m_cand*4+m_col];
            m_num     <= next_num(m_num, KEYMAP[m_cand*4+m_col]);
          end else begin
            m_run <= m_run + 1;
          end
        end else begin
          m_cand <= -1;
          m_col  <= (m_col + 1) % 4;
        end
      end else begin
        if (first_row(pressed, m_col) >= 0) m_up <= 0;
        else if (m_up + 1 >= DEB) begin
          m_held <= 1'b0;
          m_up   <= 0;
          m_col  <= (m_col + 1) % 4;
        end else begin
          m_up <= m_up + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid) kv_count <= kv_count + 1;
    num_pending <= key_valid;
    if (num_pending) num_after <= number;
  end

  task automatic wait_tick();
    do @(negedge clk); while (tb_cnt != 0);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic press_release(input logic [15:0] mask, input int hold, input int rel);
    wait_tick();
    pressed = mask;
    wait_ticks(hold);
    pressed = '0;
    wait_ticks(rel);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL reset_col_out: got %b expected 1110", col_out); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_key_code: got %0h expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    checks++; if (number !== '0) begin failures++; $display("FAIL reset_number: got %0d expected 0", number); end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    int kv0;
    logic [3:0] exp;
    kv0 = kv_count;
    checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL idle_start_col: got %b expected 1110", col_out); end
    for (int t = 0; t < 16; t++) begin
      wait_tick();
      exp = col_hot((t + 1) % 4);
      checks++; if (col_out !== exp) begin failures++; $display("FAIL idle_col tick %0d: got %b expected %b", t, col_out, exp); end
    end
    checks++; if (kv_count !== kv0) begin failures++; $display("FAIL idle_no_key: got %0d pulses expected 0", kv_count - kv0); end
  endtask

  task automatic test_single_key();
    int kv0;
    kv0 = kv_count;
    press_release(16'h0020, 10, 6);
    checks++; if (kv_count - kv0 !== 1) begin failures++; $display("FAIL key5_pulses: got %0d expected 1", kv_count - kv0); end
    checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL key5_code: got %0h expected 5", key_code); end
    checks++; if (num_after !== NW'(5)) begin failures++; $display("FAIL key5_number_next_cycle: got %0d expected 5", num_after); end
    checks++; if (number !== NW'(5)) begin failures++; $display("FAIL key5_number: got %0d expected 5", number); end
  endtask

  task automatic test_bounce();
    int kv0;
    int c0;
    logic [3:0] exp;
    kv0 = kv_count;
    wait_tick();
    c0 = m_col;
    pressed = 16'h000F;
    wait_tick();
    exp = col_hot(c0);
    checks++; if (col_out !== exp) begin failures++; $display("FAIL bounce_col_held: got %b expected %b", col_out, exp); end
    pressed = '0;
    wait_tick();
    exp = col_hot((c0 + 1) % 4);
    checks++; if (col_out !== exp) begin failures++; $display("FAIL bounce_next_col: got %b expected %b", col_out, exp); end
    wait_ticks(4);
    checks++; if (kv_count !== kv0) begin failures++; $display("FAIL bounce_no_key: got %0d pulses expected 0", kv_count - kv0); end
  endtask

  task automatic test_number_entry();
    int idx  [8] = '{3, 0, 1, 2, 4, 5, 7, 3};
    int code [8] = '{10, 1, 2, 3, 4, 5, 11, 10};
    int num  [8] = '{0, 1, 12, 123, 1234, 1234, 123, 0};
    int kv0;
    logic [15:0] mask;
    kv0 = kv_count;
    for (int i = 0; i < 8; i++) begin
      mask = 16'h0001 << idx[i];
      press_release(mask, 10, 6);
      checks++; if (key_code !== 4'(code[i])) begin failures++; $display("FAIL entry_code step %0d: got %0h expected %0h", i, key_code, code[i]); end
      checks++; if (number !== NW'(num[i])) begin failures++; $display("FAIL entry_number step %0d: got %0d expected %0d", i, number, num[i]); end
    end
    checks++; if (kv_count - kv0 !== 8) begin failures++; $display("FAIL entry_pulses: got %0d expected 8", kv_count - kv0); end
  endtask

  task automatic test_two_keys();
    int kv0;
    int c;
    logic [15:0] mask;
    kv0 = kv_count;
    c = int'($urandom_range(0, 3));
    mask = (16'h0001 << c) | (16'h0100 << c);
    press_release(mask, 10, 6);
    checks++; if (kv_count - kv0 !== 1) begin failures++; $display("FAIL two_keys_pulses: got %0d expected 1", kv_count - kv0); end
    checks++; if (key_code !== 4'(KEYMAP[c])) begin failures++; $display("FAIL two_keys_code col %0d: got %0h expected %0h", c, key_code, KEYMAP[c]); end
    checks++; if (number !== NW'(m_num)) begin failures++; $display("FAIL two_keys_number: got %0d expected %0d", number, m_num); end
  endtask

  task automatic test_held_ignore();
    int kv0;
    kv0 = kv_count;
    wait_tick();
    pressed = 16'h0020;
    wait_ticks(10);
    pressed = 16'h0220;
    wait_ticks(3);
    pressed = 16'h0200;
    wait_ticks(5);
    pressed = '0;
    wait_ticks(6);
    checks++; if (kv_count - kv0 !== 1) begin failures++; $display("FAIL held_ignore_pulses: got %0d expected 1", kv_count - kv0); end
    checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL held_ignore_code: got %0h expected 5", key_code); end
    checks++; if (number !== NW'(m_num)) begin failures++; $display("FAIL held_ignore_number: got %0d expected %0d", number, m_num); end
  endtask

  task automatic test_random_keys();
    logic [15:0] mask;
    logic [3:0]  exp;
    int hold;
    for (int i = 0; i < 12; i++) begin
      mask = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) mask = mask | (16'h0001 << $urandom_range(0, 15));
      hold = int'($urandom_range(1, 12));
      press_release(mask, hold, 7);
      exp = col_hot(m_col);
      checks++; if (kv_count !== m_accepts) begin failures++; $display("FAIL rand_pulses iter %0d: got %0d expected %0d", i, kv_count, m_accepts); end
      checks++; if (key_code !== 4'(m_code)) begin failures++; $display("FAIL rand_code iter %0d: got %0h expected %0h", i, key_code, m_code); end
      checks++; if (number !== NW'(m_num)) begin failures++; $display("FAIL rand_number iter %0d: got %0d expected %0d", i, number, m_num); end
      checks++; if (col_out !== exp) begin failures++; $display("FAIL rand_col iter %0d: got %b expected %b", i, col_out, exp); end
    end
  endtask

  task automatic test_reset_mid_debounce();
    int kv0;
    kv0 = kv_count;
    wait_tick();
    pressed = 16'h000F;
    wait_ticks(2);
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL mid_rst_col: got %b expected 1110", col_out); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL mid_rst_code: got %0h expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", key_valid); end
    checks++; if (number !== '0) begin failures++; $display("FAIL mid_rst_number: got %0d expected 0", number); end
    rst = 1'b0;
    wait_ticks(1);
    checks++; if (col_out !== 4'b1101) begin failures++; $display("FAIL mid_rst_restart_col: got %b expected 1101", col_out); end
    wait_ticks(4);
    checks++; if (kv_count !== kv0) begin failures++; $display("FAIL mid_rst_no_key: got %0d pulses expected 0", kv_count - kv0); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_bounce();
    test_number_entry();
    test_two_keys();
    test_held_ignore();
    test_random_keys();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
